// File: rtl/pdm_pkg.sv
// Shared state encoding and sample width for the PDM record/playback controller.
package pdm_pkg;

    localparam int AMP_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } rec_state_t;

endpackage

// File: rtl/pdm_rec_ctrl.sv
// Purpose: sequences PDM sample capture into an external buffer and replays it; PDM_REC_LOOP_EN selects looped playback.
// Latency: buffer write one cycle after amplitude_valid; play_valid two cycles after an accepted play_tick.
// Backpressure: none; play_tick arriving while a read is outstanding is dropped, recording stops at a full buffer.
module pdm_rec_ctrl
    import pdm_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_rec,
    input  logic              start_play,
    input  logic              stop,
    input  logic [AMP_W-1:0]  amplitude,
    input  logic              amplitude_valid,
    output logic              mic_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [AMP_W-1:0]  wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [AMP_W-1:0]  rd_data,
    input  logic              play_tick,
    output logic [AMP_W-1:0]  play_sample,
    output logic              play_valid,
    output logic [ADDR_W:0]   rec_len,
    output logic              busy
);

`ifdef PDM_REC_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    rec_state_t state;
    logic       rd_wait;   // read issued last cycle, rd_data lands this cycle
    logic       rd_last;   // the read in flight targets the final recorded sample

    logic       rd_at_end;
    assign rd_at_end = ({1'b0, rd_addr} == (rec_len - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mic_en      <= 1'b0;
            busy        <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rd_wait     <= 1'b0;
            rd_last     <= 1'b0;
            play_sample <= '0;
            play_valid  <= 1'b0;
            rec_len     <= '0;
        end else begin
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            play_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rec) begin
                        state   <= RECORD;
                        mic_en  <= 1'b1;
                        busy    <= 1'b1;
                        rec_len <= '0;
                        wr_addr <= '0;
                    end else if (start_play && rec_len != '0) begin
                        state   <= PLAY;
                        busy    <= 1'b1;
                        rd_addr <= '0;
                        rd_wait <= 1'b0;
                    end
                end
                RECORD: begin
                    // rec_len doubles as the write pointer while recording
                    if (amplitude_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= rec_len[ADDR_W-1:0];
                        wr_data <= amplitude;
                        rec_len <= rec_len + 1'b1;
                    end
                    if (stop || (amplitude_valid && rec_len == LAST_IDX)) begin
                        state  <= IDLE;
                        mic_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        rd_wait <= 1'b0;
                    end else begin
                        if (play_tick && !rd_en && !rd_wait)
                            rd_en <= 1'b1;
                        if (rd_en) begin
                            rd_wait <= 1'b1;
                            rd_last <= rd_at_end;
                            rd_addr <= (LOOP_EN && rd_at_end) ? '0 : rd_addr + 1'b1;
                        end
                        if (rd_wait) begin
                            rd_wait     <= 1'b0;
                            play_sample <= rd_data;
                            play_valid  <= 1'b1;
                            if (rd_last && !LOOP_EN) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    mic_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_rec_ctrl.sv
// Bench for pdm_rec_ctrl at DEPTH=16 with a behavioural buffer RAM and a sample-queue reference model.
`timescale 1ns/1ps
module tb_pdm_rec_ctrl;
    import pdm_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_rec = 1'b0, start_play = 1'b0, stop = 1'b0;
    logic [AMP_W-1:0] amplitude = '0;
    logic             amplitude_valid = 1'b0;
    logic             play_tick = 1'b0;
    logic             mic_en, wr_en, rd_en, play_valid, busy;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [AMP_W-1:0] wr_data, play_sample;
    logic [AMP_W-1:0] rd_data = '0;
    logic [AW:0]      rec_len;

    pdm_rec_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_rec(start_rec), .start_play(start_play), .stop(stop),
        .amplitude(amplitude), .amplitude_valid(amplitude_valid), .mic_en(mic_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .play_tick(play_tick), .play_sample(play_sample), .play_valid(play_valid),
        .rec_len(rec_len), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [AMP_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               wq_a[$];
    logic [AMP_W-1:0] wq_d[$];
    int               wq_c[$];
    logic [AMP_W-1:0] pq[$];
    int               pq_c[$];
    int               rd_cnt = 0;
    always @(negedge clk) begin
        if (wr_en) begin
            wq_a.push_back(int'(wr_addr));
            wq_d.push_back(wr_data);
            wq_c.push_back(cyc);
        end
        if (play_valid) begin
            pq.push_back(play_sample);
            pq_c.push_back(cyc);
        end
        if (rd_en) rd_cnt <= rd_cnt + 1;
    end

    logic [AMP_W-1:0] model[$];
    int               exp_c[$];
    int checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_mic_en"}, mic_en, 0);
        chk({p, "_wr_en"}, wr_en, 0);
        chk({p, "_rd_en"}, rd_en, 0);
        chk({p, "_play_valid"}, play_valid, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_wr_addr"}, wr_addr, 0);
        chk({p, "_rd_addr"}, rd_addr, 0);
        chk({p, "_wr_data"}, wr_data, 0);
        chk({p, "_play_sample"}, play_sample, 0);
        chk({p, "_rec_len"}, rec_len, 0);
    endtask

    // mode 0: fill the buffer; 1: stop with the last sample; 2: stop the cycle after the last sample
    task automatic do_record(input int n, input int mode, input bit ramp, input int exp_len);
        model.delete(); exp_c.delete();
        wq_a.delete(); wq_d.delete(); wq_c.delete();
        start_rec = 1'b1; step(); start_rec = 1'b0;
        chk("rec_mic_en", mic_en, 1);
        chk("rec_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            amplitude = ramp ? 7'(i) : 7'($urandom);
            amplitude_valid = 1'b1;
            if (mode == 1 && i == n - 1) stop = 1'b1;
            model.push_back(amplitude);
            exp_c.push_back(cyc + 1);
            step();
            amplitude_valid = 1'b0;
            stop = 1'b0;
        end
        if (mode == 2) begin
            step(); stop = 1'b1; step(); stop = 1'b0;
        end
        chk("rec_end_mic_en", mic_en, 0);
        amplitude_valid = 1'b1; amplitude = 7'h55; step(); amplitude_valid = 1'b0;
        step();
        chk("rec_end_busy", busy, 0);
        chk("rec_len", rec_len, exp_len);
        chk("rec_writes", wq_a.size(), exp_len);
        for (int i = 0; i < exp_len && i < wq_a.size(); i++) begin
            chk($sformatf("wr_addr[%0d]", i), wq_a[i], i);
            chk($sformatf("wr_data[%0d]", i), wq_d[i], model[i]);
            chk($sformatf("wr_cycle[%0d]", i), wq_c[i], exp_c[i]);
        end
    endtask

    task automatic do_play(input int nticks);
        int tc, waited, rd0;
        pq.delete(); pq_c.delete();
        start_play = 1'b1; step(); start_play = 1'b0;
        chk("play_busy", busy, 1);
        for (int k = 0; k < nticks; k++) begin
            repeat ($urandom_range(0, 3)) step();
            play_tick = 1'b1; tc = cyc + 1; step();
            play_tick = 1'($urandom_range(0, 1)); step();
            play_tick = 1'($urandom_range(0, 1)); step();
            play_tick = 1'b0;
            waited = 0;
            while (pq.size() < k + 1 && waited < 8) begin step(); waited++; end
            chk($sformatf("play_count[%0d]", k), pq.size(), k + 1);
            if (pq.size() > k) begin
                chk($sformatf("play_sample[%0d]", k), pq[k], model[k % model.size()]);
                chk($sformatf("play_latency[%0d]", k), pq_c[k] - tc, 2);
            end
        end
        step();
`ifdef PDM_REC_LOOP_EN
        chk("loop_still_busy", busy, 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("loop_stop_busy", busy, 0);
`else
        chk("play_end_busy", busy, 0);
        rd0 = rd_cnt;
        play_tick = 1'b1; step(); play_tick = 1'b0;
        repeat (4) step();
        chk("play_no_extra_rd", rd_cnt, rd0);
        chk("play_no_extra_valid", pq.size(), nticks);
`endif
    endtask

    typedef struct {
        int n;
        int mode;
        bit ramp;
        int exp_len;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int rd0;
        vecs[0] = '{n: 16, mode: 0, ramp: 1'b1, exp_len: 16};
        vecs[1] = '{n: 6,  mode: 1, ramp: 1'b0, exp_len: 6};
        vecs[2] = '{n: 1,  mode: 2, ramp: 1'b0, exp_len: 1};
        vecs[3] = '{n: 9,  mode: 2, ramp: 1'b0, exp_len: 9};

        #12;
        chk_zero("reset");
        step(); rst_n = 1'b1; step();

        // start_play with an empty buffer, stop in IDLE, then coincident starts
        start_play = 1'b1; step(); start_play = 1'b0;
        chk("empty_play_busy", busy, 0);
        step();
        chk("empty_play_rd_en", rd_cnt, 0);
        stop = 1'b1; step(); stop = 1'b0;
        chk("idle_stop_busy", busy, 0);
        start_rec = 1'b1; start_play = 1'b1; step(); start_rec = 1'b0; start_play = 1'b0;
        chk("both_start_mic_en", mic_en, 1);
        chk("both_start_busy", busy, 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("both_start_stop_busy", busy, 0);
        chk("both_start_rec_len", rec_len, 0);

        foreach (vecs[v]) begin
            do_record(vecs[v].n, vecs[v].mode, vecs[v].ramp, vecs[v].exp_len);
            do_play(vecs[v].exp_len);
        end

        // stop with a read in flight discards it
        pq.delete();
        rd0 = rd_cnt;
        start_play = 1'b1; step(); start_play = 1'b0;
        play_tick = 1'b1; step(); play_tick = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        chk("abort_busy", busy, 0);
        repeat (4) step();
        chk("abort_no_valid", pq.size(), 0);
        chk("abort_one_read", rd_cnt - rd0, 1);
        chk("abort_rec_len_kept", rec_len, 9);

`ifdef PDM_REC_LOOP_EN
        do_record(3, 1, 1'b1, 3);
        do_play(7);
`endif

        // reset while recording at count 8
        start_rec = 1'b1; step(); start_rec = 1'b0;
        for (int i = 0; i < 8; i++) begin
            amplitude = 7'($urandom); amplitude_valid = 1'b1; step();
        end
        amplitude_valid = 1'b0;
        chk("pre_reset_rec_len", rec_len, 8);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrec_reset");
        step(); rst_n = 1'b1; step();
        chk("post_reset_rec_len", rec_len, 0);
        start_play = 1'b1; step(); start_play = 1'b0;
        chk("post_reset_play_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
